// File: rtl/unidad_control_multiciclo.sv
// Multicycle control unit: Moore FSM sequencing fetch, decode, memory,
// R-type, branch and immediate instructions. Outputs decode from the state
// register; only the FETCH/MEM_WR completion strobes look at mem_ready.
module unidad_control_multiciclo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OP,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUop,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EXEC   = 4'd7,
    R_WB     = 4'd8,
    BEQ      = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11,
    ILLEGAL  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;

  // State and latched opcode registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state and output decode; everything defaults to 0 / hold
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 3'b000;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = DECODE;
      end

      DECODE: begin
        ALUSrcB = 2'b11;
        op_d    = OP;
        case (OP)
          OP_RTYPE:                          state_d = R_EXEC;
          OP_LW, OP_SW:                      state_d = MEM_ADDR;
          OP_BEQ:                            state_d = BEQ;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = I_EXEC;
          default:                           state_d = ILLEGAL;
        endcase
      end

      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      end

      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end

      MEM_WB: begin
        MemToReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end

      MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = FETCH;
      end

      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 3'b010;
        state_d = R_WB;
      end

      R_WB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end

      BEQ: begin
        ALUSrcA     = 1'b1;
        ALUop       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
        state_d     = FETCH;
      end

      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op_q)
          OP_SLTI: ALUop = 3'b100;
          OP_ANDI: ALUop = 3'b101;
          OP_ORI:  ALUop = 3'b011;
          default: ALUop = 3'b000;
        endcase
        state_d = I_WB;
      end

      I_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end

      ILLEGAL: illegal = 1'b1;

      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Scoreboard bench for the multicycle control unit: the stimulus process
// pushes a hand-written expected output vector for every cycle it drives,
// and a monitor on the falling edge pops and compares.
module tb_unidad_control_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] OP = 6'b000000;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemToReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUop;
  logic       instr_done, illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  unidad_control_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .PCSource(PCSource), .instr_done(instr_done), .illegal(illegal),
    .state(state)
  );

  // Field order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite RegDst
  // MemToReg RegWrite ALUSrcA _ ALUSrcB _ ALUop _ PCSource _ instr_done illegal _ state
  localparam logic [22:0] E_IDLE    = 23'b0000000000_00_000_00_00_0000;
  localparam logic [22:0] E_FWAIT   = 23'b0001000000_01_000_00_00_0001;
  localparam logic [22:0] E_FGO     = 23'b1001010000_01_000_00_00_0001;
  localparam logic [22:0] E_DECODE  = 23'b0000000000_11_000_00_00_0010;
  localparam logic [22:0] E_MADDR   = 23'b0000000001_10_000_00_00_0011;
  localparam logic [22:0] E_MRD     = 23'b0011000000_00_000_00_00_0100;
  localparam logic [22:0] E_MWB     = 23'b0000000110_00_000_00_10_0101;
  localparam logic [22:0] E_MWRWAIT = 23'b0010100000_00_000_00_00_0110;
  localparam logic [22:0] E_MWRGO   = 23'b0010100000_00_000_00_10_0110;
  localparam logic [22:0] E_REXEC   = 23'b0000000001_00_010_00_00_0111;
  localparam logic [22:0] E_RWB     = 23'b0000001010_00_000_00_10_1000;
  localparam logic [22:0] E_BEQ     = 23'b0100000001_00_001_01_10_1001;
  localparam logic [22:0] E_IADD    = 23'b0000000001_10_000_00_00_1010;
  localparam logic [22:0] E_ISLT    = 23'b0000000001_10_100_00_00_1010;
  localparam logic [22:0] E_IAND    = 23'b0000000001_10_101_00_00_1010;
  localparam logic [22:0] E_IOR     = 23'b0000000001_10_011_00_00_1010;
  localparam logic [22:0] E_IWB     = 23'b0000000010_00_000_00_10_1011;
  localparam logic [22:0] E_ILL     = 23'b0000000000_00_000_00_01_1100;

  localparam logic [5:0] JUNK = 6'b111111;

  typedef struct {
    logic [22:0] exp;
    string       name;
  } sb_entry_t;

  sb_entry_t sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Drive one cycle of inputs and queue the outputs expected during it
  task automatic step(input logic rn, input logic rdy, input logic [5:0] op,
                      input logic [22:0] exp, input string name);
    sb_entry_t e;
    @(posedge clk);
    #1;
    rst_n     = rn;
    mem_ready = rdy;
    OP        = op;
    e.exp     = exp;
    e.name    = name;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation plus the strobe exclusivity rules
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_entry_t   e;
      logic [22:0] got;
      e   = sb.pop_front();
      got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
             MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource,
             instr_done, illegal, state};
      n_tests++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, got, e.exp);
      end
      n_tests++;
      if ((MemRead && MemWrite) || (RegWrite && MemWrite)) begin
        n_fail++;
        $display("FAIL %s excl: MemRead=%b MemWrite=%b RegWrite=%b want no overlap",
                 e.name, MemRead, MemWrite, RegWrite);
      end
    end
  end

  initial begin
    // Reset and release
    step(0, 1, 6'b000000, E_IDLE,   "reset_idle");
    step(1, 1, 6'b000000, E_IDLE,   "idle_release");

    // R-type: 1,2,7,8
    step(1, 1, 6'b000000, E_FGO,    "r_fetch");
    step(1, 1, 6'b000000, E_DECODE, "r_decode");
    step(1, 1, JUNK,      E_REXEC,  "r_exec");
    step(1, 1, JUNK,      E_RWB,    "r_wb");

    // BEQ: 3 cycles
    step(1, 1, JUNK,      E_FGO,    "beq_fetch");
    step(1, 1, 6'b000100, E_DECODE, "beq_decode");
    step(1, 1, 6'b100011, E_BEQ,    "beq_exec");

    // LW with 2-cycle MEM_RD stall; OP changes after decode are ignored
    step(1, 1, 6'b000000, E_FGO,    "lw_fetch");
    step(1, 1, 6'b100011, E_DECODE, "lw_decode");
    step(1, 1, 6'b101011, E_MADDR,  "lw_addr");
    step(1, 0, 6'b101011, E_MRD,    "lw_rd_wait1");
    step(1, 0, JUNK,      E_MRD,    "lw_rd_wait2");
    step(1, 1, JUNK,      E_MRD,    "lw_rd_go");
    step(1, 1, JUNK,      E_MWB,    "lw_wb");

    // SW with one MEM_WR stall cycle
    step(1, 1, JUNK,      E_FGO,    "sw_fetch");
    step(1, 1, 6'b101011, E_DECODE, "sw_decode");
    step(1, 1, 6'b100011, E_MADDR,  "sw_addr");
    step(1, 0, JUNK,      E_MWRWAIT,"sw_wr_wait");
    step(1, 1, JUNK,      E_MWRGO,  "sw_wr_go");

    // FETCH stall of 3 cycles, then ADDI
    step(1, 0, JUNK,      E_FWAIT,  "fetch_wait1");
    step(1, 0, JUNK,      E_FWAIT,  "fetch_wait2");
    step(1, 0, JUNK,      E_FWAIT,  "fetch_wait3");
    step(1, 1, JUNK,      E_FGO,    "addi_fetch");
    step(1, 1, 6'b001000, E_DECODE, "addi_decode");
    step(1, 1, 6'b001010, E_IADD,   "addi_exec");
    step(1, 1, JUNK,      E_IWB,    "addi_wb");

    // Remaining I-type opcodes
    step(1, 1, JUNK,      E_FGO,    "slti_fetch");
    step(1, 1, 6'b001010, E_DECODE, "slti_decode");
    step(1, 1, 6'b001000, E_ISLT,   "slti_exec");
    step(1, 1, JUNK,      E_IWB,    "slti_wb");
    step(1, 1, JUNK,      E_FGO,    "andi_fetch");
    step(1, 1, 6'b001100, E_DECODE, "andi_decode");
    step(1, 1, JUNK,      E_IAND,   "andi_exec");
    step(1, 1, JUNK,      E_IWB,    "andi_wb");
    step(1, 1, JUNK,      E_FGO,    "ori_fetch");
    step(1, 1, 6'b001101, E_DECODE, "ori_decode");
    step(1, 1, JUNK,      E_IOR,    "ori_exec");
    step(1, 1, JUNK,      E_IWB,    "ori_wb");

    // Reset while stalled in MEM_WR
    step(1, 1, JUNK,      E_FGO,    "swr_fetch");
    step(1, 1, 6'b101011, E_DECODE, "swr_decode");
    step(1, 0, JUNK,      E_MADDR,  "swr_addr");
    step(0, 0, JUNK,      E_MWRWAIT,"swr_wr_in_reset");
    step(1, 0, JUNK,      E_IDLE,   "swr_idle");
    step(1, 1, JUNK,      E_FGO,    "swr_refetch");

    // Unknown opcode: ILLEGAL held 10 cycles, then reset clears it
    step(1, 1, JUNK,      E_DECODE, "ill_decode");
    for (int i = 0; i < 10; i++)
      step(1, i[0], 6'b000000, E_ILL, $sformatf("ill_hold%0d", i));
    step(0, 1, 6'b000000, E_ILL,    "ill_in_reset");
    step(1, 1, 6'b000000, E_IDLE,   "ill_cleared");
    step(1, 1, 6'b000000, E_FGO,    "ill_refetch");

    // Let the monitor drain, bounded
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
